// File: rtl/viterbi_blk_ctrl_if.sv
// Purpose: bundles every non-clock/reset signal of the Viterbi block sequencer.
//   slave  : the sequencer's view (viterbi_blk_ctrl drives its outputs).
//   master : the environment's view (symbol source, BMC/ACS/survivor memory,
//            traceback unit and decoded-bit sink).
// Signals:
//   in_valid/in_ready/rx_pair_in    received symbol pair handshake
//   rx_pair, acs_en, acs_init       branch-metric / ACS controls
//   surv_we, surv_waddr             survivor memory write port
//   tb_rd_en, tb_start, tb_raddr    traceback read port
//   tb_bit                          traced bit, one cycle after tb_rd_en
//   dec_valid/dec_ready/dec_bit     decoded bit handshake, oldest bit first
interface viterbi_blk_ctrl_if #(
  parameter int TB_DEPTH = 16
);
  localparam int AW = $clog2(TB_DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    rx_pair_in;
  logic [1:0]    rx_pair;
  logic          acs_en;
  logic          acs_init;
  logic          surv_we;
  logic [AW-1:0] surv_waddr;
  logic          tb_rd_en;
  logic          tb_start;
  logic [AW-1:0] tb_raddr;
  logic          tb_bit;
  logic          dec_valid;
  logic          dec_ready;
  logic          dec_bit;

  modport master (
    output in_valid, rx_pair_in, tb_bit, dec_ready,
    input  in_ready, rx_pair, acs_en, acs_init, surv_we, surv_waddr,
           tb_rd_en, tb_start, tb_raddr, dec_valid, dec_bit
  );

  modport slave (
    input  in_valid, rx_pair_in, tb_bit, dec_ready,
    output in_ready, rx_pair, acs_en, acs_init, surv_we, surv_waddr,
           tb_rd_en, tb_start, tb_raddr, dec_valid, dec_bit
  );
endinterface

// File: rtl/viterbi_blk_ctrl.sv
// Purpose: block-mode sequencer for a rate-1/2 Viterbi decoder. Collects
//   TB_DEPTH symbol pairs (pulsing ACS and survivor writes per symbol), waits one
//   cycle for the last survivor write, walks the survivor memory backwards,
//   buffers the traced bits by address and finally emits them oldest-first.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    viterbi_blk_ctrl_if.slave, all handshake and memory-control signals
// All outputs come straight from registers.
module viterbi_blk_ctrl #(
  parameter int TB_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  viterbi_blk_ctrl_if.slave  bus
);
  localparam int AW = $clog2(TB_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(TB_DEPTH - 1);
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    DRAIN = 3'd1,
    TRACE = 3'd2,
    TLAST = 3'd3,
    EMIT  = 3'd4
  } state_t;

  state_t              state_r, state_nx_s;
  logic [AW-1:0]       wcnt_r, wcnt_nx_s;
  logic [AW-1:0]       ocnt_r, ocnt_nx_s;
  logic [TB_DEPTH-1:0] bits_r, bits_nx_s;
  logic                cap_en_r;
  logic [AW-1:0]       cap_addr_r;

  logic          in_ready_r,   in_ready_nx_s;
  logic [1:0]    rx_pair_r,    rx_pair_nx_s;
  logic          acs_en_r,     acs_en_nx_s;
  logic          acs_init_r,   acs_init_nx_s;
  logic          surv_we_r,    surv_we_nx_s;
  logic [AW-1:0] surv_waddr_r, surv_waddr_nx_s;
  logic          tb_rd_en_r,   tb_rd_en_nx_s;
  logic          tb_start_r,   tb_start_nx_s;
  logic [AW-1:0] tb_raddr_r,   tb_raddr_nx_s;
  logic          dec_valid_r,  dec_valid_nx_s;
  logic          dec_bit_r,    dec_bit_nx_s;

  logic accept_s;
  logic dec_xfer_s;

  // in_ready_r is only ever high in FILL, so it doubles as the accept qualifier.
  assign accept_s   = bus.in_valid & in_ready_r;
  assign dec_xfer_s = bus.dec_ready & dec_valid_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_nx_s      = state_r;
    wcnt_nx_s       = wcnt_r;
    ocnt_nx_s       = ocnt_r;
    rx_pair_nx_s    = rx_pair_r;
    acs_en_nx_s     = 1'b0;
    acs_init_nx_s   = 1'b0;
    surv_we_nx_s    = 1'b0;
    surv_waddr_nx_s = surv_waddr_r;
    tb_rd_en_nx_s   = 1'b0;
    tb_start_nx_s   = 1'b0;
    tb_raddr_nx_s   = tb_raddr_r;
    dec_valid_nx_s  = dec_valid_r;
    dec_bit_nx_s    = dec_bit_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          rx_pair_nx_s    = bus.rx_pair_in;
          acs_en_nx_s     = 1'b1;
          surv_we_nx_s    = 1'b1;
          surv_waddr_nx_s = wcnt_r;
          acs_init_nx_s   = (wcnt_r == ZERO_IDX);
          wcnt_nx_s       = wcnt_r + ONE_IDX;
          if (wcnt_r == LAST_IDX) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = FILL;
          end
        end else begin
          state_nx_s = FILL;
        end
      end
      DRAIN: begin
        // Last survivor write lands this cycle; first read goes out next cycle.
        state_nx_s    = TRACE;
        tb_rd_en_nx_s = 1'b1;
        tb_start_nx_s = 1'b1;
        tb_raddr_nx_s = LAST_IDX;
      end
      TRACE: begin
        if (tb_raddr_r == ZERO_IDX) begin
          state_nx_s = TLAST;
        end else begin
          state_nx_s    = TRACE;
          tb_rd_en_nx_s = 1'b1;
          tb_raddr_nx_s = tb_raddr_r - ONE_IDX;
        end
      end
      TLAST: begin
        // buf[0] is written on this same edge, so bit 0 is taken from tb_bit.
        state_nx_s     = EMIT;
        ocnt_nx_s      = ZERO_IDX;
        dec_valid_nx_s = 1'b1;
        dec_bit_nx_s   = bus.tb_bit;
      end
      EMIT: begin
        if (dec_xfer_s) begin
          ocnt_nx_s = ocnt_r + ONE_IDX;
          if (ocnt_r == LAST_IDX) begin
            state_nx_s     = FILL;
            dec_valid_nx_s = 1'b0;
            dec_bit_nx_s   = 1'b0;
          end else begin
            state_nx_s   = EMIT;
            dec_bit_nx_s = bits_r[ocnt_nx_s];
          end
        end else begin
          state_nx_s = EMIT;
        end
      end
      default: begin
        state_nx_s = FILL;
      end
    endcase
    in_ready_nx_s = (state_nx_s == FILL);
  end

  // Traceback capture: the bit arriving one cycle after a read is stored at that read's address.
  always_comb begin
    bits_nx_s = bits_r;
    if (cap_en_r) begin
      bits_nx_s[cap_addr_r] = bus.tb_bit;
    end else begin
      bits_nx_s = bits_r;
    end
  end

  // Counters, capture pipeline, bit buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r       <= ZERO_IDX;
      ocnt_r       <= ZERO_IDX;
      bits_r       <= {TB_DEPTH{1'b0}};
      cap_en_r     <= 1'b0;
      cap_addr_r   <= ZERO_IDX;
      in_ready_r   <= 1'b0;
      rx_pair_r    <= 2'b00;
      acs_en_r     <= 1'b0;
      acs_init_r   <= 1'b0;
      surv_we_r    <= 1'b0;
      surv_waddr_r <= ZERO_IDX;
      tb_rd_en_r   <= 1'b0;
      tb_start_r   <= 1'b0;
      tb_raddr_r   <= ZERO_IDX;
      dec_valid_r  <= 1'b0;
      dec_bit_r    <= 1'b0;
    end else begin
      wcnt_r       <= wcnt_nx_s;
      ocnt_r       <= ocnt_nx_s;
      bits_r       <= bits_nx_s;
      cap_en_r     <= tb_rd_en_r;
      cap_addr_r   <= tb_raddr_r;
      in_ready_r   <= in_ready_nx_s;
      rx_pair_r    <= rx_pair_nx_s;
      acs_en_r     <= acs_en_nx_s;
      acs_init_r   <= acs_init_nx_s;
      surv_we_r    <= surv_we_nx_s;
      surv_waddr_r <= surv_waddr_nx_s;
      tb_rd_en_r   <= tb_rd_en_nx_s;
      tb_start_r   <= tb_start_nx_s;
      tb_raddr_r   <= tb_raddr_nx_s;
      dec_valid_r  <= dec_valid_nx_s;
      dec_bit_r    <= dec_bit_nx_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.rx_pair    = rx_pair_r;
  assign bus.acs_en     = acs_en_r;
  assign bus.acs_init   = acs_init_r;
  assign bus.surv_we    = surv_we_r;
  assign bus.surv_waddr = surv_waddr_r;
  assign bus.tb_rd_en   = tb_rd_en_r;
  assign bus.tb_start   = tb_start_r;
  assign bus.tb_raddr   = tb_raddr_r;
  assign bus.dec_valid  = dec_valid_r;
  assign bus.dec_bit    = dec_bit_r;
endmodule

// File: tb/tb_viterbi_blk_ctrl.sv
// Bench for viterbi_blk_ctrl. A timeline model predicts every output from the
// number of accepted symbols and the cycle distance to the block's last accept.
// A stub traceback unit returns bit pat[block][raddr] one cycle after each read.
module tb_viterbi_blk_ctrl;
  localparam int TB_DEPTH = 16;

  logic clk;
  logic rst_n;

  viterbi_blk_ctrl_if #(.TB_DEPTH(TB_DEPTH)) bus_if ();

  viterbi_blk_ctrl #(.TB_DEPTH(TB_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] pat [0:15];
  int stub_gen = 0;

  // model state
  logic       fresh     = 1'b1;
  int         t_done    = -1;
  int         accepted  = 0;
  int         emitted   = 0;
  logic       prev_acc  = 1'b0;
  logic [1:0] prev_pair = 2'b00;
  int         prev_idx  = 0;
  int         m_gen     = 0;
  int         dut_acs_cnt = 0;
  logic [15:0] dut_word = 16'h0000;
  int         dut_nbits = 0;
  logic       pin_done  = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Traceback stub: answers each read one cycle later.
  initial begin : tb_stub
    logic       rd;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      rd = bus_if.tb_rd_en;
      a  = bus_if.tb_raddr;
      if (rd && bus_if.tb_start) stub_gen = stub_gen + 1;
      @(posedge clk);
      #1;
      if (rd) bus_if.tb_bit = pat[stub_gen % 16][a];
      else    bus_if.tb_bit = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: checks DUT outputs against the model every cycle, then advances the model.
  initial begin : compare
    int   d;
    logic exp_rdy, exp_rd, exp_emit, acc, xfer, last_dv;
    last_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_in_ready",   16'(bus_if.in_ready),   16'h0);
        check("rst_rx_pair",    16'(bus_if.rx_pair),    16'h0);
        check("rst_acs_en",     16'(bus_if.acs_en),     16'h0);
        check("rst_acs_init",   16'(bus_if.acs_init),   16'h0);
        check("rst_surv_we",    16'(bus_if.surv_we),    16'h0);
        check("rst_surv_waddr", 16'(bus_if.surv_waddr), 16'h0);
        check("rst_tb_rd_en",   16'(bus_if.tb_rd_en),   16'h0);
        check("rst_tb_start",   16'(bus_if.tb_start),   16'h0);
        check("rst_tb_raddr",   16'(bus_if.tb_raddr),   16'h0);
        check("rst_dec_valid",  16'(bus_if.dec_valid),  16'h0);
        check("rst_dec_bit",    16'(bus_if.dec_bit),    16'h0);
        fresh = 1'b1; t_done = -1; accepted = 0; emitted = 0;
        prev_acc = 1'b0; dut_acs_cnt = 0;
      end else begin
        d        = cyc - t_done;
        exp_rdy  = !fresh && (t_done < 0);
        exp_rd   = (t_done >= 0) && (d >= 2) && (d <= TB_DEPTH + 1);
        exp_emit = (t_done >= 0) && (d >= TB_DEPTH + 3);

        check("in_ready", 16'(bus_if.in_ready), 16'(exp_rdy));
        check("acs_en",   16'(bus_if.acs_en),   16'(prev_acc));
        check("surv_we",  16'(bus_if.surv_we),  16'(prev_acc));
        check("acs_init", 16'(bus_if.acs_init), 16'(prev_acc && (prev_idx == 0)));
        if (prev_acc) begin
          check("surv_waddr", 16'(bus_if.surv_waddr), 16'(prev_idx));
          check("rx_pair",    16'(bus_if.rx_pair),    16'(prev_pair));
        end
        check("tb_rd_en", 16'(bus_if.tb_rd_en), 16'(exp_rd));
        check("tb_start", 16'(bus_if.tb_start), 16'((t_done >= 0) && (d == 2)));
        if (exp_rd) check("tb_raddr", 16'(bus_if.tb_raddr), 16'(TB_DEPTH + 1 - d));
        check("dec_valid", 16'(bus_if.dec_valid), 16'(exp_emit));
        if (exp_emit) begin
          check("dec_bit", 16'(bus_if.dec_bit), 16'(pat[m_gen % 16][emitted]));
        end

        // literal pins on the model
        if (bus_if.dec_valid && !last_dv && (t_done >= 0)) begin
          check("latency_19", 16'(cyc - t_done), 16'd19);
        end
        if ((t_done >= 0) && (d == TB_DEPTH + 2)) begin
          check("acs_pulses_16", 16'(dut_acs_cnt), 16'd16);
          dut_acs_cnt = 0;
        end
        if (bus_if.dec_valid && bus_if.dec_ready && !pin_done) begin
          dut_word  = {bus_if.dec_bit, dut_word[15:1]};
          dut_nbits = dut_nbits + 1;
          if (dut_nbits == 16) begin
            check("first_block_bits", dut_word, 16'hAAAA);
            pin_done = 1'b1;
          end
        end
        if (bus_if.acs_en) dut_acs_cnt = dut_acs_cnt + 1;

        // advance model to the next cycle
        acc  = bus_if.in_valid && exp_rdy;
        xfer = exp_emit && bus_if.dec_ready;
        if ((t_done >= 0) && (d == 2)) m_gen = m_gen + 1;
        prev_acc  = acc;
        prev_pair = bus_if.rx_pair_in;
        prev_idx  = accepted;
        if (acc) begin
          accepted = accepted + 1;
          if (accepted == TB_DEPTH) t_done = cyc;
        end
        if (xfer) begin
          emitted = emitted + 1;
          if (emitted == TB_DEPTH) begin
            t_done = -1; accepted = 0; emitted = 0;
          end
        end
        fresh = 1'b0;
      end
      last_dv = bus_if.dec_valid;
      cyc = cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus.
  initial begin : stim
    logic found;
    for (int g = 0; g < 16; g++) pat[g] = 16'($urandom);
    pat[1] = 16'hAAAA;  // first block: tb_bit = parity of tb_raddr

    rst_n = 1'b0;
    bus_if.in_valid   = 1'b1;
    bus_if.rx_pair_in = 2'b00;
    bus_if.dec_ready  = 1'b1;
    bus_if.tb_bit     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // two back-to-back blocks, no stalls
    for (int i = 0; i < 100; i++) begin
      bus_if.rx_pair_in = 2'($urandom);
      step();
    end

    // input bubbles
    for (int i = 0; i < 120; i++) begin
      bus_if.in_valid   = (i % 2 == 0);
      bus_if.rx_pair_in = 2'($urandom);
      step();
    end

    // output backpressure mid-EMIT
    bus_if.in_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus_if.dec_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_checks = n_checks + 1;
    if (!found) begin
      n_fail = n_fail + 1;
      $display("FAIL wait_dec_valid: not seen within 150 cycles");
    end
    step();
    repeat (3) step();
    bus_if.dec_ready = 1'b0;
    repeat (5) step();
    bus_if.dec_ready = 1'b1;

    // reset in the middle of TRACE at raddr 9
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.tb_rd_en && (bus_if.tb_raddr == 4'd9)) begin
        found = 1'b1;
        break;
      end
    end
    n_checks = n_checks + 1;
    if (!found) begin
      n_fail = n_fail + 1;
      $display("FAIL wait_raddr9: not seen within 200 cycles");
    end
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic on both handshakes
    for (int i = 0; i < 300; i++) begin
      bus_if.in_valid   = ($urandom_range(0, 3) != 0);
      bus_if.dec_ready  = ($urandom_range(0, 3) != 0);
      bus_if.rx_pair_in = 2'($urandom);
      step();
    end

    bus_if.in_valid  = 1'b0;
    bus_if.dec_ready = 1'b1;
    repeat (80) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
